// File: rtl/rv32im_ram_arbiter.sv
// rtl/rv32im_ram_arbiter.sv - round-robin two-port arbiter for the shared data RAM
// One transaction in flight at a time; IDLE -> ACCESS -> (WAIT) -> RESP.
module rv32im_ram_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MASK_WIDTH  = 4,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    input  logic [MASK_WIDTH-1:0] m0_wmask_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic [MASK_WIDTH-1:0] m1_wmask_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic [MASK_WIDTH-1:0] ram_wmask_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  busy_o
);

    if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_latency
        $error("rv32im_ram_arbiter: RAM_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state, state_next;
    logic                  last_owner;
    logic                  owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MASK_WIDTH-1:0] wmask_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [2:0]            cnt;
    logic                  gnt0, gnt1, accept;

    // Contention goes to the port that did not win last time.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == S_IDLE && reset_n) begin
            if (m0_req_i && m1_req_i) begin
                gnt0 = last_owner;
                gnt1 = ~last_owner;
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    assign accept = gnt0 | gnt1;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_ACCESS;
            S_ACCESS: state_next = (wmask_q != '0) ? S_RESP : S_WAIT;
            S_WAIT:   if (cnt == 3'd1) state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_owner <= 1'b1;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            cnt        <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner_q    <= gnt1;
                        last_owner <= gnt1;
                        addr_q     <= gnt1 ? m1_addr_i  : m0_addr_i;
                        wdata_q    <= gnt1 ? m1_wdata_i : m0_wdata_i;
                        wmask_q    <= gnt1 ? m1_wmask_i : m0_wmask_i;
                        rdata_q    <= '0;
                    end
                end
                S_ACCESS: begin
                    if (wmask_q == '0) cnt <= 3'(RAM_LATENCY);
                end
                S_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) rdata_q <= ram_rdata_i;
                end
                default: ;
            endcase
        end
    end

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign busy_o      = (state != S_IDLE);
    assign ram_en_o    = (state == S_ACCESS);
    assign ram_addr_o  = ram_en_o ? addr_q  : '0;
    assign ram_wdata_o = ram_en_o ? wdata_q : '0;
    assign ram_wmask_o = ram_en_o ? wmask_q : '0;
    assign m0_rvalid_o = (state == S_RESP) && !owner_q;
    assign m1_rvalid_o = (state == S_RESP) &&  owner_q;
    assign m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;

endmodule

// File: tb/tb_rv32im_ram_arbiter.sv
// tb/tb_rv32im_ram_arbiter.sv - directed bench for rv32im_ram_arbiter
// Two instances share all inputs: u_l1 has RAM_LATENCY=1, u_l3 has RAM_LATENCY=3.
module tb_rv32im_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wmask = '0, m1_wmask = '0;
    logic [31:0] ram_rdata = '0;

    logic        g0_1, g1_1, v0_1, v1_1, en_1, busy_1;
    logic [31:0] d0_1, d1_1, a_1, w_1;
    logic [3:0]  k_1;
    logic        g0_3, g1_3, v0_3, v1_3, en_3, busy_3;
    logic [31:0] d0_3, d1_3, a_3, w_3;
    logic [3:0]  k_3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv32im_ram_arbiter #(.RAM_LATENCY(1)) u_l1 (
        .clk(clk), .reset_n(reset_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wmask_i(m0_wmask),
        .m0_gnt_o(g0_1), .m0_rvalid_o(v0_1), .m0_rdata_o(d0_1),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wmask_i(m1_wmask),
        .m1_gnt_o(g1_1), .m1_rvalid_o(v1_1), .m1_rdata_o(d1_1),
        .ram_en_o(en_1), .ram_addr_o(a_1), .ram_wdata_o(w_1), .ram_wmask_o(k_1),
        .ram_rdata_i(ram_rdata), .busy_o(busy_1)
    );

    rv32im_ram_arbiter #(.RAM_LATENCY(3)) u_l3 (
        .clk(clk), .reset_n(reset_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wmask_i(m0_wmask),
        .m0_gnt_o(g0_3), .m0_rvalid_o(v0_3), .m0_rdata_o(d0_3),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wmask_i(m1_wmask),
        .m1_gnt_o(g1_3), .m1_rvalid_o(v1_3), .m1_rdata_o(d1_3),
        .ram_en_o(en_3), .ram_addr_o(a_3), .ram_wdata_o(w_3), .ram_wmask_o(k_3),
        .ram_rdata_i(ram_rdata), .busy_o(busy_3)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each cycle's inputs are applied 1ns after the rising edge; checks follow 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        m0_req = 1'b0; m1_req = 1'b0; ram_rdata = '0;
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] seq_rd [3];
        seq_rd[0] = 32'h1111_1111; seq_rd[1] = 32'h2222_2222; seq_rd[2] = 32'hCAFE_F00D;

        // Reset state
        tick();
        settle();
        chk1("rst_busy", busy_1, 1'b0);
        chk1("rst_en", en_1, 1'b0);
        chk32("rst_addr", a_1, 32'h0);
        chk1("rst_rvalid0", v0_1, 1'b0);
        chk1("rst_rvalid1", v1_1, 1'b0);

        // 1: L=1 read of 0x100
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h100; m0_wmask = 4'h0;
        settle();
        chk1("t1_gnt0_T0", g0_1, 1'b1);
        chk1("t1_gnt1_T0", g1_1, 1'b0);
        tick(); m0_req = 1'b0; m0_addr = 32'hFFFF_FFFF; settle();
        chk1("t1_en_T1", en_1, 1'b1);
        chk32("t1_addr_T1", a_1, 32'h100);
        chk32("t1_mask_T1", {28'h0, k_1}, 32'h0);
        tick(); ram_rdata = 32'hDEAD_BEEF; settle();
        chk1("t1_en_T2", en_1, 1'b0);
        chk1("t1_rvalid_T2", v0_1, 1'b0);
        tick(); ram_rdata = 32'h0; settle();
        chk1("t1_rvalid_T3", v0_1, 1'b1);
        chk32("t1_rdata_T3", d0_1, 32'hDEAD_BEEF);
        chk1("t1_m1rvalid_T3", v1_1, 1'b0);
        tick(); settle();
        chk1("t1_rvalid_T4", v0_1, 1'b0);
        chk1("t1_busy_T4", busy_1, 1'b0);

        // 2: m1 write
        do_reset();
        m1_req = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h1234_5678; m1_wmask = 4'b0011;
        settle();
        chk1("t2_gnt1_T0", g1_1, 1'b1);
        chk1("t2_gnt0_T0", g0_1, 1'b0);
        tick(); m1_req = 1'b0; m1_wdata = 32'h0; settle();
        chk1("t2_en_T1", en_1, 1'b1);
        chk32("t2_addr_T1", a_1, 32'h40);
        chk32("t2_wdata_T1", w_1, 32'h1234_5678);
        chk32("t2_mask_T1", {28'h0, k_1}, 32'h3);
        tick(); settle();
        chk1("t2_rvalid1_T2", v1_1, 1'b1);
        chk32("t2_rdata1_T2", d1_1, 32'h0);
        chk1("t2_rvalid0_T2", v0_1, 1'b0);
        chk32("t2_rdata0_T2", d0_1, 32'h0);
        chk32("t2_ramw_T2", w_1, 32'h0);
        tick(); settle();
        chk1("t2_busy_T3", busy_1, 1'b0);
        chk1("t2_rvalid1_T3", v1_1, 1'b0);

        // 3: both requesting writes from reset release -> m0,m1,m0,m1
        m0_req = 1'b1; m1_req = 1'b1; m0_wmask = 4'hF; m1_wmask = 4'hF;
        reset_n = 1'b0; settle();
        chk1("t3_gnt0_inreset", g0_1, 1'b0);
        tick(); tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk1("t3_gnt0_idle", g0_1, (k % 2) == 0);
            chk1("t3_gnt1_idle", g1_1, (k % 2) == 1);
            tick(); settle();
            chk1("t3_gnt0_T1", g0_1, 1'b0);
            chk1("t3_gnt1_T1", g1_1, 1'b0);
            tick(); settle();
            chk1("t3_gnt_T2", g0_1 | g1_1, 1'b0);
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0; m0_wmask = 4'h0; m1_wmask = 4'h0;

        // 4: L=3 read
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h300;
        settle();
        chk1("t4_gnt0_T0", g0_3, 1'b1);
        chk1("t4_busy_T0", busy_3, 1'b0);
        tick(); m0_req = 1'b0; settle();
        chk1("t4_busy_T1", busy_3, 1'b1);
        chk1("t4_en_T1", en_3, 1'b1);
        chk32("t4_addr_T1", a_3, 32'h300);
        chk32("t4_mask_T1", {28'h0, k_3}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick(); ram_rdata = seq_rd[c]; settle();
            chk1("t4_busy_wait", busy_3, 1'b1);
            chk1("t4_en_wait", en_3, 1'b0);
            chk32("t4_ramw_wait", w_3, 32'h0);
            chk1("t4_rvalid_wait", v0_3, 1'b0);
            chk1("t4_gnt1_wait", g1_3, 1'b0);
        end
        tick(); ram_rdata = 32'h3333_3333; settle();
        chk1("t4_rvalid_T5", v0_3, 1'b1);
        chk32("t4_rdata_T5", d0_3, 32'hCAFE_F00D);
        chk1("t4_busy_T5", busy_3, 1'b1);
        chk1("t4_m1rvalid_T5", v1_3, 1'b0);
        chk32("t4_m1rdata_T5", d1_3, 32'h0);
        tick(); settle();
        chk1("t4_rvalid_T6", v0_3, 1'b0);
        chk1("t4_busy_T6", busy_3, 1'b0);

        // 5: reset during WAIT aborts the read
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h500;
        tick(); m0_req = 1'b0;
        tick(); settle();
        chk1("t5_busy_pre", busy_3, 1'b1);
        reset_n = 1'b0; settle();
        chk1("t5_busy_rst", busy_3, 1'b0);
        chk1("t5_en_rst", en_3, 1'b0);
        chk1("t5_rvalid_rst", v0_3, 1'b0);
        tick(); reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk1("t5_no_stale_l3", v0_3, 1'b0);
            chk1("t5_no_stale_l1", v0_1, 1'b0);
            tick();
        end
        m0_req = 1'b1; m1_req = 1'b1; settle();
        chk1("t5_contend_gnt0", g0_3, 1'b1);
        chk1("t5_contend_gnt1", g1_3, 1'b0);
        chk1("t5_contend_gnt0_l1", g0_1, 1'b1);
        tick(); m0_req = 1'b0; m1_req = 1'b0;

        // 6: m1 request raised during an m0 read is held off until IDLE
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h200; m0_wmask = 4'h0;
        tick(); m0_req = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h44; m1_wdata = 32'hA5A5_A5A5; m1_wmask = 4'hF;
        settle();
        chk1("t6_gnt1_T1", g1_1, 1'b0);
        tick(); ram_rdata = 32'h0BAD_F00D; settle();
        chk1("t6_gnt1_T2", g1_1, 1'b0);
        tick(); ram_rdata = 32'h0; settle();
        chk1("t6_gnt1_T3", g1_1, 1'b0);
        chk1("t6_rvalid0_T3", v0_1, 1'b1);
        chk32("t6_rdata0_T3", d0_1, 32'h0BAD_F00D);
        tick(); settle();
        chk1("t6_gnt1_T4", g1_1, 1'b1);
        tick(); m1_req = 1'b0; settle();
        chk1("t6_en_T5", en_1, 1'b1);
        chk32("t6_addr_T5", a_1, 32'h44);
        chk32("t6_wdata_T5", w_1, 32'hA5A5_A5A5);
        chk32("t6_mask_T5", {28'h0, k_1}, 32'hF);
        tick(); settle();
        chk1("t6_rvalid1_T6", v1_1, 1'b1);
        chk32("t6_rdata1_T6", d1_1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
